// File: rtl/cavlc_pkg.sv
// Shared constants and types for the CAVLC bitstream front end and its decoders.
package cavlc_pkg;

  localparam int CAVLC_IN_W      = 32;
  localparam int CAVLC_WIN_W     = 16;
  localparam int CAVLC_BUF_W     = 64;
  localparam int CAVLC_MAX_SHIFT = 16;

  typedef logic [4:0] cavlc_shamt_t;
  typedef logic [6:0] cavlc_bitcnt_t;

  function automatic cavlc_bitcnt_t cavlc_widen_shamt(input cavlc_shamt_t amt);
    return {2'b00, amt};
  endfunction

endpackage

// File: rtl/cavlc_bitstream_aligner_if.sv
// Word-in / window-out bundle between the slice-data feeder, the aligner and the decoders.
interface cavlc_bitstream_aligner_if;
  import cavlc_pkg::*;

  logic                   Flush;
  logic [CAVLC_IN_W-1:0]  InData;
  logic                   InValid;
  logic                   InReady;
  logic                   ShiftEn;
  cavlc_shamt_t           ShiftAmt;
  logic [CAVLC_WIN_W-1:0] Window;
  logic                   WindowValid;
  cavlc_bitcnt_t          BitCount;
  logic [31:0]            BitsConsumed;
  logic                   ShiftErr;

  modport master (
    output Flush, InData, InValid, ShiftEn, ShiftAmt,
    input  InReady, Window, WindowValid, BitCount, BitsConsumed, ShiftErr
  );

  modport slave (
    input  Flush, InData, InValid, ShiftEn, ShiftAmt,
    output InReady, Window, WindowValid, BitCount, BitsConsumed, ShiftErr
  );

endinterface

// File: rtl/cavlc_bit_merge.sv
// Next-state buffer: drop the consumed bits off the top, then append an incoming
// word directly below the surviving bits.
module cavlc_bit_merge
  import cavlc_pkg::*;
#(
  parameter int IN_W  = CAVLC_IN_W,
  parameter int BUF_W = CAVLC_BUF_W
) (
  input  logic [BUF_W-1:0] bits_cur,
  input  cavlc_bitcnt_t    cnt_cur,
  input  cavlc_bitcnt_t    shamt,
  input  logic [IN_W-1:0]  data,
  input  logic             load,
  output logic [BUF_W-1:0] bits_nxt,
  output cavlc_bitcnt_t    cnt_nxt
);

  cavlc_bitcnt_t    fill;
  logic [BUF_W-1:0] word_aligned;

  always_comb begin
    fill         = cnt_cur - shamt;
    word_aligned = {data, {(BUF_W-IN_W){1'b0}}} >> fill;
    bits_nxt     = bits_cur << shamt;
    cnt_nxt      = fill;
    if (load) begin
      bits_nxt = bits_nxt | word_aligned;
      cnt_nxt  = fill + cavlc_bitcnt_t'(IN_W);
    end
  end

endmodule

// File: rtl/cavlc_bitstream_aligner.sv
// Bit aligner: buffers up to two input words and exposes an MSB-aligned window
// that advances by the decoder's per-symbol shift amount.
module cavlc_bitstream_aligner
  import cavlc_pkg::*;
#(
  parameter int IN_WIDTH  = CAVLC_IN_W,
  parameter int WIN_WIDTH = CAVLC_WIN_W,
  parameter int BUF_WIDTH = CAVLC_BUF_W,
  parameter int MAX_SHIFT = CAVLC_MAX_SHIFT
) (
  input logic                 Clk,
  input logic                 Reset,
  cavlc_bitstream_aligner_if.slave bus
);

  logic [BUF_WIDTH-1:0] sreg_p0;
  cavlc_bitcnt_t        cnt_p0;
  logic [31:0]          consumed_p0;
  logic                 err_p0;

  cavlc_bitcnt_t        shamt;
  cavlc_bitcnt_t        s;
  logic                 shift_ok;
  logic                 shift_bad;
  logic                 ready;
  logic                 load;
  logic [BUF_WIDTH-1:0] sreg_nxt;
  cavlc_bitcnt_t        cnt_nxt;

  // Room for one more word only while at most half the buffer is occupied.
  assign ready = !Reset && !bus.Flush && (cnt_p0 <= cavlc_bitcnt_t'(BUF_WIDTH - IN_WIDTH));
  assign load  = bus.InValid && ready;

  always_comb begin
    shamt     = cavlc_widen_shamt(bus.ShiftAmt);
    shift_ok  = bus.ShiftEn && (shamt <= cavlc_bitcnt_t'(MAX_SHIFT)) && (shamt <= cnt_p0);
    shift_bad = bus.ShiftEn && !shift_ok;
    s         = shift_ok ? shamt : '0;
  end

  cavlc_bit_merge #(
    .IN_W  (IN_WIDTH),
    .BUF_W (BUF_WIDTH)
  ) u_merge (
    .bits_cur (sreg_p0),
    .cnt_cur  (cnt_p0),
    .shamt    (s),
    .data     (bus.InData),
    .load     (load),
    .bits_nxt (sreg_nxt),
    .cnt_nxt  (cnt_nxt)
  );

  // Stage p0: buffer, fill level, consumed-bit counter and sticky error.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sreg_p0     <= '0;
      cnt_p0      <= '0;
      consumed_p0 <= '0;
      err_p0      <= 1'b0;
    end else if (bus.Flush) begin
      sreg_p0     <= '0;
      cnt_p0      <= '0;
      consumed_p0 <= '0;
      err_p0      <= 1'b0;
    end else begin
      sreg_p0     <= sreg_nxt;
      cnt_p0      <= cnt_nxt;
      consumed_p0 <= consumed_p0 + 32'(s);
      if (shift_bad) begin
        err_p0 <= 1'b1;
      end
    end
  end

  assign bus.InReady      = ready;
  assign bus.Window       = sreg_p0[BUF_WIDTH-1 -: WIN_WIDTH];
  assign bus.WindowValid  = (cnt_p0 >= cavlc_bitcnt_t'(WIN_WIDTH));
  assign bus.BitCount     = cnt_p0;
  assign bus.BitsConsumed = consumed_p0;
  assign bus.ShiftErr     = err_p0;

endmodule

// File: tb/tb_cavlc_bitstream_aligner.sv
// Directed and randomized checks of the aligner against a bit-queue stream model.
module tb_cavlc_bitstream_aligner;

  logic Clk = 1'b0;
  logic Reset;

  cavlc_bitstream_aligner_if ifc ();

  cavlc_bitstream_aligner dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifc.slave)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Model: the buffered stream as a queue of bits, oldest first.
  bit          q[$];
  int unsigned m_cons = 0;
  bit          m_err  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_window();
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++)
      if (i < q.size()) w[15-i] = q[i];
    return w;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_window"},   32'(ifc.Window),      32'(model_window()));
    chk({tag, "_bitcount"}, 32'(ifc.BitCount),    32'(q.size()));
    chk({tag, "_wvalid"},   32'(ifc.WindowValid), 32'(q.size() >= 16));
    chk({tag, "_consumed"}, ifc.BitsConsumed,     m_cons);
    chk({tag, "_err"},      32'(ifc.ShiftErr),    32'(m_err));
  endtask

  task automatic model_step(input bit fl, input bit vld, input logic [31:0] d,
                            input bit sen, input int amt);
    bit rdy;
    if (fl) begin
      q.delete();
      m_cons = 0;
      m_err  = 0;
      return;
    end
    rdy = (q.size() <= 32);
    if (sen) begin
      if (amt <= 16 && amt <= q.size()) begin
        for (int i = 0; i < amt; i++) void'(q.pop_front());
        m_cons += amt;
      end else begin
        m_err = 1;
      end
    end
    if (vld && rdy)
      for (int i = 31; i >= 0; i--) q.push_back(d[i]);
  endtask

  task automatic idle_inputs();
    ifc.Flush    = 1'b0;
    ifc.InValid  = 1'b0;
    ifc.InData   = '0;
    ifc.ShiftEn  = 1'b0;
    ifc.ShiftAmt = '0;
  endtask

  task automatic cycle(input string tag, input bit fl, input bit vld, input logic [31:0] d,
                       input bit sen, input logic [4:0] amt);
    ifc.Flush    = fl;
    ifc.InValid  = vld;
    ifc.InData   = d;
    ifc.ShiftEn  = sen;
    ifc.ShiftAmt = amt;
    #1;
    chk({tag, "_inready"}, 32'(ifc.InReady), 32'(!fl && q.size() <= 32));
    @(posedge Clk);
    model_step(fl, vld, d, sen, int'(amt));
    #1;
    check_all(tag);
  endtask

  initial begin
    idle_inputs();
    Reset = 1'b1;
    #2;
    chk("rst_inready", 32'(ifc.InReady), 32'd0);
    check_all("rst");
    #10;
    Reset = 1'b0;
    #1;
    chk("rel_inready", 32'(ifc.InReady), 32'd1);

    // Two words back to back, then the buffer is full.
    cycle("load1", 0, 1, 32'hDEADBEEF, 0, 5'd0);
    chk("load1_dead", 32'(ifc.Window), 32'h0000DEAD);
    chk("load1_cnt",  32'(ifc.BitCount), 32'd32);
    cycle("load2", 0, 1, 32'h12345678, 0, 5'd0);
    chk("load2_cnt",   32'(ifc.BitCount), 32'd64);
    chk("load2_ready", 32'(ifc.InReady),  32'd0);
    cycle("full_hold", 0, 1, 32'hCAFEF00D, 0, 5'd0);

    cycle("sh4", 0, 0, 32'h0, 1, 5'd4);
    chk("sh4_eadb", 32'(ifc.Window), 32'h0000EADB);
    chk("sh4_cons", ifc.BitsConsumed, 32'd4);
    cycle("sh16", 0, 0, 32'h0, 1, 5'd16);
    cycle("sh0",  0, 0, 32'h0, 1, 5'd0);
    chk("sh0_cons", ifc.BitsConsumed, 32'd20);

    // Concurrent load and shift from a 20-bit fill of ABCDE.
    cycle("fl1",  1, 1, 32'h11111111, 1, 5'd4);
    cycle("pre",  0, 1, 32'h000ABCDE, 0, 5'd0);
    cycle("trim", 0, 0, 32'h0, 1, 5'd12);
    cycle("conc", 0, 1, 32'h01234567, 1, 5'd8);
    chk("conc_cnt", 32'(ifc.BitCount), 32'd44);
    chk("conc_win", 32'(ifc.Window),   32'h0000CDE0);

    // Illegal shifts.
    cycle("fl2",   1, 0, 32'h0, 0, 5'd0);
    cycle("i_ld",  0, 1, 32'hA5A5F00F, 0, 5'd0);
    cycle("i_s16", 0, 0, 32'h0, 1, 5'd16);
    cycle("i_s6",  0, 0, 32'h0, 1, 5'd6);
    cycle("i_bad", 0, 0, 32'h0, 1, 5'd12);
    chk("i_bad_err", 32'(ifc.ShiftErr), 32'd1);
    chk("i_bad_cnt", 32'(ifc.BitCount), 32'd10);
    cycle("i_ld2", 0, 1, 32'h13579BDF, 1, 5'd10);
    cycle("i_ld3", 0, 1, 32'h2468ACE0, 0, 5'd0);
    cycle("i_17",  0, 0, 32'h0, 1, 5'd17);
    chk("i_17_cnt", 32'(ifc.BitCount), 32'd64);
    cycle("i_fl",  1, 0, 32'h0, 0, 5'd0);
    chk("i_fl_err", 32'(ifc.ShiftErr), 32'd0);

    // Flush wins over a load and a shift in the same cycle.
    cycle("f_ld",  0, 1, 32'h89ABCDEF, 0, 5'd0);
    cycle("f_all", 1, 1, 32'hFFFFFFFF, 1, 5'd3);
    chk("f_all_cnt",  32'(ifc.BitCount),  32'd0);
    chk("f_all_cons", ifc.BitsConsumed,   32'd0);

    // Asynchronous reset between edges while 48 bits are buffered.
    cycle("r_ld1", 0, 1, 32'h0F0F0F0F, 0, 5'd0);
    cycle("r_ld2", 0, 1, 32'h33CC33CC, 0, 5'd0);
    cycle("r_sh",  0, 0, 32'h0, 1, 5'd16);
    chk("r_sh_cnt", 32'(ifc.BitCount), 32'd48);
    idle_inputs();
    #2;
    Reset = 1'b1;
    #1;
    q.delete();
    m_cons = 0;
    m_err  = 0;
    chk("arst_inready", 32'(ifc.InReady), 32'd0);
    check_all("arst");
    #1;
    Reset = 1'b0;
    #1;
    chk("arst_rel_inready", 32'(ifc.InReady), 32'd1);
    chk("arst_rel_cnt",     32'(ifc.BitCount), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bit          fl, vld, sen;
      logic [4:0]  amt;
      logic [31:0] d;
      fl  = ($urandom_range(0, 39) == 0);
      vld = ($urandom_range(0, 3) != 0);
      sen = ($urandom_range(0, 2) != 0);
      d   = $urandom;
      amt = ($urandom_range(0, 11) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      cycle("rnd", fl, vld, d, sen, amt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
